// File: rtl/tsn_cmd_pkg.sv
// Shared definitions for the command-bus arbiter: default widths, timeout
// and the two-state controller encoding.
package tsn_cmd_pkg;

  localparam int CMD_W           = 204;
  localparam int ACK_TIMEOUT_DEF = 255;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

endpackage

// File: rtl/cmd_bus_arbiter_rr_arb2.sv
// Two-requester round-robin grant; ptr names the requester that wins a tie.
// No grant is issued while advance is low.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] grant
);

  // grant selection
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Arbitrates two requesters onto shared write/read command buses and routes
// the read acknowledge (or a timeout indication) back to the read's owner.
module cmd_bus_arbiter #(
  parameter int CMD_W       = tsn_cmd_pkg::CMD_W,
  parameter int ACK_TIMEOUT = tsn_cmd_pkg::ACK_TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CMD_W-1:0] iv_cmd_0,
  input  logic [CMD_W-1:0] iv_cmd_1,
  input  logic             i_cmd_rd_0,
  input  logic             i_cmd_rd_1,
  input  logic             i_cmd_valid_0,
  input  logic             i_cmd_valid_1,
  output logic             o_cmd_ready_0,
  output logic             o_cmd_ready_1,
  output logic [CMD_W-1:0] ov_wr_command,
  output logic             o_wr_command_wr,
  output logic [CMD_W-1:0] ov_rd_command,
  output logic             o_rd_command_wr,
  input  logic [CMD_W-1:0] iv_rd_command_ack,
  input  logic             i_rd_command_ack_wr,
  output logic [CMD_W-1:0] ov_ack,
  output logic             o_ack_valid_0,
  output logic             o_ack_valid_1,
  output logic             o_ack_timeout
);
  import tsn_cmd_pkg::*;

  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [CMD_W-1:0] wr_cmd_q, wr_cmd_d;
  logic             wr_stb_q, wr_stb_d;
  logic [CMD_W-1:0] rd_cmd_q, rd_cmd_d;
  logic             rd_stb_q, rd_stb_d;
  logic [CMD_W-1:0] ack_q, ack_d;
  logic             av0_q, av0_d;
  logic             av1_q, av1_d;
  logic             ato_q, ato_d;

  logic [1:0]       grant_s;
  logic             advance_s;
  logic [CMD_W-1:0] sel_cmd_s;
  logic             sel_rd_s;

  // Readies are granted only in IDLE and never while reset is held.
  assign advance_s = (state_q == IDLE) & ~i_rst;

  rr_arb2 u_rr_arb2 (
    .req     ({i_cmd_valid_1, i_cmd_valid_0}),
    .ptr     (ptr_q),
    .advance (advance_s),
    .grant   (grant_s)
  );

  assign o_cmd_ready_0 = grant_s[0];
  assign o_cmd_ready_1 = grant_s[1];
  assign sel_cmd_s     = grant_s[1] ? iv_cmd_1 : iv_cmd_0;
  assign sel_rd_s      = grant_s[1] ? i_cmd_rd_1 : i_cmd_rd_0;

  // next-state and output computation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    wr_cmd_d = wr_cmd_q;
    wr_stb_d = 1'b0;
    rd_cmd_d = rd_cmd_q;
    rd_stb_d = 1'b0;
    ack_d    = ack_q;
    av0_d    = 1'b0;
    av1_d    = 1'b0;
    ato_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant_s) begin
          ptr_d = ~grant_s[1];
          if (sel_rd_s) begin
            rd_cmd_d = sel_cmd_s;
            rd_stb_d = 1'b1;
            owner_d  = grant_s[1];
            cnt_d    = 16'd0;
            state_d  = WAIT_ACK;
          end else begin
            wr_cmd_d = sel_cmd_s;
            wr_stb_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 16'd1;
        // An ack arriving in the expiry cycle wins over the timeout.
        if (i_rd_command_ack_wr) begin
          ack_d   = iv_rd_command_ack;
          av0_d   = ~owner_q;
          av1_d   = owner_q;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          ack_d   = '0;
          ato_d   = 1'b1;
          av0_d   = ~owner_q;
          av1_d   = owner_q;
          state_d = IDLE;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= 16'd0;
      wr_cmd_q <= '0;
      wr_stb_q <= 1'b0;
      rd_cmd_q <= '0;
      rd_stb_q <= 1'b0;
      ack_q    <= '0;
      av0_q    <= 1'b0;
      av1_q    <= 1'b0;
      ato_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      wr_cmd_q <= wr_cmd_d;
      wr_stb_q <= wr_stb_d;
      rd_cmd_q <= rd_cmd_d;
      rd_stb_q <= rd_stb_d;
      ack_q    <= ack_d;
      av0_q    <= av0_d;
      av1_q    <= av1_d;
      ato_q    <= ato_d;
    end
  end

  assign ov_wr_command   = wr_cmd_q;
  assign o_wr_command_wr = wr_stb_q;
  assign ov_rd_command   = rd_cmd_q;
  assign o_rd_command_wr = rd_stb_q;
  assign ov_ack          = ack_q;
  assign o_ack_valid_0   = av0_q;
  assign o_ack_valid_1   = av1_q;
  assign o_ack_timeout   = ato_q;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Two arbiters (ack timeout 255 and 4) share one stimulus stream; each is
// compared every cycle against a transaction-level reference model.
module tb_cmd_bus_arbiter;

  localparam int W = 204;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] cmd0, cmd1, ackd;
  logic         rd0, rd1, v0, v1, ackwr;

  logic         rdy0 [2];
  logic         rdy1 [2];
  logic         wrs  [2];
  logic         rds  [2];
  logic         av0  [2];
  logic         av1  [2];
  logic         ato  [2];
  logic [W-1:0] wrc  [2];
  logic [W-1:0] rdc  [2];
  logic [W-1:0] ackq [2];

  cmd_bus_arbiter #(.CMD_W(W), .ACK_TIMEOUT(255)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .iv_cmd_0(cmd0), .iv_cmd_1(cmd1),
    .i_cmd_rd_0(rd0), .i_cmd_rd_1(rd1),
    .i_cmd_valid_0(v0), .i_cmd_valid_1(v1),
    .o_cmd_ready_0(rdy0[0]), .o_cmd_ready_1(rdy1[0]),
    .ov_wr_command(wrc[0]), .o_wr_command_wr(wrs[0]),
    .ov_rd_command(rdc[0]), .o_rd_command_wr(rds[0]),
    .iv_rd_command_ack(ackd), .i_rd_command_ack_wr(ackwr),
    .ov_ack(ackq[0]), .o_ack_valid_0(av0[0]), .o_ack_valid_1(av1[0]),
    .o_ack_timeout(ato[0])
  );

  cmd_bus_arbiter #(.CMD_W(W), .ACK_TIMEOUT(4)) dut_t (
    .i_clk(clk), .i_rst(rst),
    .iv_cmd_0(cmd0), .iv_cmd_1(cmd1),
    .i_cmd_rd_0(rd0), .i_cmd_rd_1(rd1),
    .i_cmd_valid_0(v0), .i_cmd_valid_1(v1),
    .o_cmd_ready_0(rdy0[1]), .o_cmd_ready_1(rdy1[1]),
    .ov_wr_command(wrc[1]), .o_wr_command_wr(wrs[1]),
    .ov_rd_command(rdc[1]), .o_rd_command_wr(rds[1]),
    .iv_rd_command_ack(ackd), .i_rd_command_ack_wr(ackwr),
    .ov_ack(ackq[1]), .o_ack_valid_0(av0[1]), .o_ack_valid_1(av1[1]),
    .o_ack_timeout(ato[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model state, one entry per arbiter
  int           lim    [2] = '{255, 4};
  bit           busy   [2];
  int           owner  [2];
  int           waited [2];
  int           rr     [2];
  int           gs     [2];
  logic [W-1:0] e_wr   [2];
  logic [W-1:0] e_rd   [2];
  logic [W-1:0] e_ack  [2];
  bit           e_wrs  [2];
  bit           e_rds  [2];
  bit           e_av0  [2];
  bit           e_av1  [2];
  bit           e_to   [2];

  task automatic chk(input string tag, input int k, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input int k, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  function automatic int granted(int k);
    if (rst || busy[k]) return -1;
    if (v0 && v1) return rr[k];
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic model_edge(input int k);
    int g;
    g = gs[k];
    e_wrs[k] = 1'b0; e_rds[k] = 1'b0;
    e_av0[k] = 1'b0; e_av1[k] = 1'b0; e_to[k] = 1'b0;
    if (rst) begin
      busy[k] = 1'b0; rr[k] = 0; owner[k] = 0; waited[k] = 0;
      e_wr[k] = '0; e_rd[k] = '0; e_ack[k] = '0;
    end else if (busy[k]) begin
      waited[k]++;
      if (ackwr) begin
        e_ack[k] = ackd;
        e_av0[k] = (owner[k] == 0); e_av1[k] = (owner[k] == 1);
        busy[k]  = 1'b0;
      end else if (waited[k] == lim[k]) begin
        e_ack[k] = '0;
        e_to[k]  = 1'b1;
        e_av0[k] = (owner[k] == 0); e_av1[k] = (owner[k] == 1);
        busy[k]  = 1'b0;
      end
    end else if (g >= 0) begin
      rr[k] = 1 - g;
      if ((g == 1) ? rd1 : rd0) begin
        e_rd[k]   = (g == 1) ? cmd1 : cmd0;
        e_rds[k]  = 1'b1;
        busy[k]   = 1'b1;
        owner[k]  = g;
        waited[k] = 0;
      end else begin
        e_wr[k]  = (g == 1) ? cmd1 : cmd0;
        e_wrs[k] = 1'b1;
      end
    end
  endtask

  // One clock: check readies mid-cycle, then registered outputs after the edge.
  task automatic step();
    #4;
    for (int k = 0; k < 2; k++) begin
      gs[k] = granted(k);
      chk_b("ready0", k, rdy0[k], gs[k] == 0);
      chk_b("ready1", k, rdy1[k], gs[k] == 1);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      chk_b("wr_stb", k, wrs[k], e_wrs[k]);
      chk  ("wr_cmd", k, wrc[k], e_wr[k]);
      chk_b("rd_stb", k, rds[k], e_rds[k]);
      chk  ("rd_cmd", k, rdc[k], e_rd[k]);
      chk  ("ack",    k, ackq[k], e_ack[k]);
      chk_b("ack_v0", k, av0[k], e_av0[k]);
      chk_b("ack_v1", k, av1[k], e_av1[k]);
      chk_b("ack_to", k, ato[k], e_to[k]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; rr[k] = 0; owner[k] = 0; waited[k] = 0; gs[k] = -1;
      e_wr[k] = '0; e_rd[k] = '0; e_ack[k] = '0;
    end
    cmd0 = W'(4'hA); cmd1 = W'(4'hB); ackd = '0;
    rd0 = 1'b0; rd1 = 1'b0; ackwr = 1'b0;

    // reset held with both requesters valid
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
    repeat (3) step();

    // round-robin writes A/B, requester 0 first
    rst = 1'b0;
    repeat (6) step();

    // requester 1 read 0x55, ack 0x1234 ten cycles later, writes pending meanwhile
    v0 = 1'b0; v1 = 1'b1; rd1 = 1'b1; cmd1 = W'(8'h55);
    step();
    v1 = 1'b0; rd1 = 1'b0; v0 = 1'b1;
    repeat (9) step();
    ackwr = 1'b1; ackd = W'(16'h1234);
    step();
    ackwr = 1'b0; v0 = 1'b0;
    step();

    // requester 0 read with no ack: timeout on the short-timeout arbiter
    v0 = 1'b1; rd0 = 1'b1; cmd0 = W'(8'h77);
    step();
    v0 = 1'b0; rd0 = 1'b0;
    repeat (6) step();

    // ack landing exactly in the expiry cycle
    v0 = 1'b1; rd0 = 1'b1; cmd0 = W'(8'h99);
    step();
    v0 = 1'b0; rd0 = 1'b0;
    repeat (3) step();
    ackwr = 1'b1; ackd = W'(20'hBEEF5);
    step();
    ackwr = 1'b0;
    repeat (2) step();

    // stray ack while idle
    ackwr = 1'b1; ackd = W'(12'hDAD);
    step();
    ackwr = 1'b0;
    step();

    // reset in the middle of a read, then a late ack
    v1 = 1'b1; rd1 = 1'b1; cmd1 = W'(8'h3C);
    step();
    v1 = 1'b0; rd1 = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0; ackwr = 1'b1; ackd = W'(8'hEE);
    step();
    ackwr = 1'b0;
    repeat (2) step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      v0    = 1'($urandom_range(0, 1));
      v1    = 1'($urandom_range(0, 1));
      rd0   = ($urandom_range(0, 3) == 0);
      rd1   = ($urandom_range(0, 3) == 0);
      cmd0  = rnd_w();
      cmd1  = rnd_w();
      ackd  = rnd_w();
      ackwr = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmd_bus_arbiter.md
CMD_BUS_ARBITER -- requirements
Module: cmd_bus_arbiter

Interface
REQ-001 The block SHALL have parameter CMD_W, default 204, meaning command/ack bus width.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning cycles to wait for a read ack (legal range 1..65535).
REQ-003 The block SHALL have port i_clk  in  1  system clock, 125 MHz; the only clock.
REQ-004 The block SHALL have port i_rst  in  1  synchronous reset, active-high.
REQ-005 The block SHALL have ports iv_cmd_0 / iv_cmd_1  in  CMD_W  requester 0/1 command.
REQ-006 The block SHALL have ports i_cmd_rd_0 / i_cmd_rd_1  in  1  command type (1 = read, 0 = write).
REQ-007 The block SHALL have ports i_cmd_valid_0 / i_cmd_valid_1  in  1  requester 0/1 command valid.
REQ-008 The block SHALL have ports o_cmd_ready_0 / o_cmd_ready_1  out  1  requester 0/1 command accepted.
REQ-009 The block SHALL have ports ov_wr_command  out  CMD_W  and  o_wr_command_wr  out  1, forming the shared write-command bus.
REQ-010 The block SHALL have ports ov_rd_command  out  CMD_W  and  o_rd_command_wr  out  1, forming the shared read-command bus.
REQ-011 The block SHALL have ports iv_rd_command_ack  in  CMD_W  and  i_rd_command_ack_wr  in  1, carrying read-ack data and its strobe.
REQ-012 The block SHALL have ports ov_ack  out  CMD_W,  o_ack_valid_0 / o_ack_valid_1  out  1  and  o_ack_timeout  out  1, returning read results to the originating requester.

Function
REQ-013 The block SHALL implement the states IDLE and WAIT_ACK.
REQ-014 In IDLE the block SHALL assert, combinationally, exactly one o_cmd_ready_x, granting the valid requester; when both requesters are valid it SHALL grant the one selected by the round-robin pointer.
REQ-015 A handshake SHALL be valid_x & ready_x in cycle T; on each handshake the pointer SHALL move to the other requester.
REQ-016 An accepted write SHALL drive ov_wr_command and a one-cycle o_wr_command_wr pulse at T+1; the state SHALL remain IDLE, so writes can be accepted back-to-back at 1/cycle.
REQ-017 An accepted read SHALL drive ov_rd_command and a one-cycle o_rd_command_wr pulse at T+1, and SHALL enter WAIT_ACK at T+1, recording the owner requester.
REQ-018 In WAIT_ACK both ready outputs SHALL be 0.
REQ-019 In WAIT_ACK, i_rd_command_ack_wr SHALL cause ov_ack to capture iv_rd_command_ack and o_ack_valid_owner to pulse for 1 cycle at the next edge with o_ack_timeout = 0; the state SHALL then return to IDLE.
REQ-020 A 16-bit timeout counter SHALL clear on entering WAIT_ACK and increment each WAIT_ACK cycle; when it reaches ACK_TIMEOUT without an ack, the block SHALL return a pulse on o_ack_valid_owner with o_ack_timeout = 1 and ov_ack = 0, then return to IDLE.
REQ-021 When an ack and timeout expiry occur in the same cycle, the ack SHALL take precedence and o_ack_timeout SHALL be 0.
REQ-022 i_rd_command_ack_wr SHALL be ignored while in IDLE (stray ack); no outputs change.
REQ-023 ov_wr_command, ov_rd_command and ov_ack SHALL hold their last values between strobes; the strobes and o_ack_timeout SHALL be single-cycle pulses.
REQ-024 The block SHALL never issue a write and a read in the same cycle, nor more than one command per cycle.

Reset
REQ-025 While i_rst = 1 the block SHALL set state to IDLE, pointer to 0, counter to 0, and all outputs to 0 (including ready outputs).
REQ-026 Reset asserted in WAIT_ACK SHALL abort the read with no ack pulse; a later ack SHALL be ignored.

Structure
REQ-027 A shared package tsn_cmd_pkg SHALL hold CMD_W, the default ACK_TIMEOUT, and the state encoding (IDLE = 1'b0, WAIT_ACK = 1'b1).
REQ-028 The two-input round-robin grant SHALL be a sub-module rr_arb2 (inputs: req[1:0], ptr, advance; outputs: grant[1:0]).

Verification
REQ-029 Reset behaviour: hold i_rst = 1 for 3 cycles with both valids high -> all outputs 0; first grant after release goes to requester 0.
REQ-030 Round-robin writes: both requesters continuously valid with writes 0xA (req0) and 0xB (req1) -> o_wr_command_wr high every cycle, ov_wr_command alternating A, B, A, B.
REQ-031 Read with ack: requester 1 issues read 0x55; ack 0x1234 arrives 10 cycles later -> one o_ack_valid_1 pulse with ov_ack = 0x1234, o_ack_timeout = 0, readies 0 throughout the wait.
REQ-032 Read timeout: ACK_TIMEOUT = 4 and no ack -> o_ack_valid_0 & o_ack_timeout pulse exactly 4 cycles after entering WAIT_ACK, with ov_ack = 0.
REQ-033 Boundary ack/timeout: ack in the expiry cycle -> ack data returned with o_ack_timeout = 0; a stray ack in IDLE -> no pulse.
REQ-034 Reset mid-read: assert i_rst in WAIT_ACK, then deliver an ack -> no o_ack_valid pulse and the block is in IDLE.
